mlp_cfg_sequencer: RTL

- Receives a byte-serial configuration stream from the UART controller and assembles it into the MLP activation-pipeline registers: norm gain, norm bias, norm shift, quantiser inverse scale and quantiser zero point.
- Writes go to shadow registers. A commit copies them to the active outputs only while the MLP reports idle, and any start request that arrives meanwhile is held back.
- Sits between the UART controller and MLP top, replacing the fixed identity configuration on the MLP config ports.

---
 rtl/mlp_cfg_sequencer.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mlp_cfg_sequencer.sv
// mlp_cfg_sequencer
// Assembles a byte-serial configuration stream into the MLP activation
// pipeline registers (norm gain/bias/shift, quantiser inverse scale and
// zero point). Frames land in shadow registers; a commit frame copies the
// shadows into the active outputs once the MLP reports idle. MLP start
// requests that arrive while a commit is outstanding are held and replayed
// as a single pulse right after the new configuration becomes active.
//
// Optional build feature: define MLP_CFG_READBACK_EN to add a registered
// readback port (rd_sel / rd_data) for the active registers.

module mlp_cfg_sequencer #(
    parameter logic [3:0]  IDLE_STATE    = 4'd0,
    parameter int unsigned FRAME_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    input  logic [7:0]         cfg_data,
    output logic               cfg_ready,
    input  logic               ctrl_start_mlp,
    input  logic [3:0]         mlp_state_in,
    output logic               mlp_start_mlp,
    output logic signed [15:0] mlp_norm_gain,
    output logic signed [31:0] mlp_norm_bias,
    output logic [4:0]         mlp_norm_shift,
    output logic signed [15:0] mlp_q_inv_scale,
    output logic signed [7:0]  mlp_q_zero_point,
    output logic               commit_pending,
    output logic               cfg_err
`ifdef MLP_CFG_READBACK_EN
    ,
    input  logic [2:0]         rd_sel,
    output logic [31:0]        rd_data
`endif
);

    // Header ids
    localparam logic [7:0] ID_GAIN   = 8'd0;
    localparam logic [7:0] ID_BIAS   = 8'd1;
    localparam logic [7:0] ID_SHIFT  = 8'd2;
    localparam logic [7:0] ID_INVSC  = 8'd3;
    localparam logic [7:0] ID_ZP     = 8'd4;
    localparam logic [7:0] ID_COMMIT = 8'hFF;

    // Identity configuration used at reset for both shadow and active copies
    localparam logic signed [15:0] DEF_GAIN  = 16'sd256;
    localparam logic signed [31:0] DEF_BIAS  = 32'sd0;
    localparam logic [4:0]         DEF_SHIFT = 5'd8;
    localparam logic signed [15:0] DEF_INVSC = 16'sd256;
    localparam logic signed [7:0]  DEF_ZP    = 8'sd0;

    // Timeout counter only needs to reach FRAME_TIMEOUT-1
    localparam int TW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_PAY   = 2'd1,
        S_CWAIT = 2'd2
    } state_t;

    // Payload length in bytes for a valid data id
    function automatic logic [2:0] payload_len(input logic [2:0] id);
        case (id)
            3'd0:    return 3'd2;
            3'd1:    return 3'd4;
            3'd3:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         id_q, id_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [31:0]        stg_q, stg_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               pending_q, pending_d;
    logic               err_q, err_d;
    logic               held_q, held_d;

    logic signed [15:0] sh_gain_q, sh_gain_d;
    logic signed [31:0] sh_bias_q, sh_bias_d;
    logic [4:0]         sh_shift_q, sh_shift_d;
    logic signed [15:0] sh_invsc_q, sh_invsc_d;
    logic signed [7:0]  sh_zp_q, sh_zp_d;

    logic signed [15:0] act_gain_q, act_gain_d;
    logic signed [31:0] act_bias_q, act_bias_d;
    logic [4:0]         act_shift_q, act_shift_d;
    logic signed [15:0] act_invsc_q, act_invsc_d;
    logic signed [7:0]  act_zp_q, act_zp_d;

    logic               timeout_hit;

    // The frame is dropped once FRAME_TIMEOUT idle cycles have elapsed in PAY
    assign timeout_hit = (FRAME_TIMEOUT != 0) &&
                         (32'(tcnt_q) == FRAME_TIMEOUT - 32'd1);

    assign cfg_ready        = (state_q != S_CWAIT);
    assign commit_pending   = pending_q;
    assign cfg_err          = err_q;
    // Pass-through start unless a commit is outstanding; replay a held start
    assign mlp_start_mlp    = !pending_q && (ctrl_start_mlp || held_q);

    assign mlp_norm_gain    = act_gain_q;
    assign mlp_norm_bias    = act_bias_q;
    assign mlp_norm_shift   = act_shift_q;
    assign mlp_q_inv_scale  = act_invsc_q;
    assign mlp_q_zero_point = act_zp_q;

    // Next-state logic: frame parsing, shadow writes, commit and start hold
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        stg_d       = stg_q;
        tcnt_d      = tcnt_q;
        pending_d   = pending_q;
        err_d       = err_q;
        held_d      = held_q;
        sh_gain_d   = sh_gain_q;
        sh_bias_d   = sh_bias_q;
        sh_shift_d  = sh_shift_q;
        sh_invsc_d  = sh_invsc_q;
        sh_zp_d     = sh_zp_q;
        act_gain_d  = act_gain_q;
        act_bias_d  = act_bias_q;
        act_shift_d = act_shift_q;
        act_invsc_d = act_invsc_q;
        act_zp_d    = act_zp_q;

        case (state_q)
            S_HDR: begin
                if (cfg_valid) begin
                    if (cfg_data == ID_COMMIT) begin
                        pending_d = 1'b1;
                        state_d   = S_CWAIT;
                    end else if (cfg_data <= ID_ZP) begin
                        id_d    = cfg_data[2:0];
                        cnt_d   = payload_len(cfg_data[2:0]);
                        tcnt_d  = '0;
                        state_d = S_PAY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_PAY: begin
                if (cfg_valid) begin
                    // LSB-first bytes shift in from the top; a complete
                    // n-byte field ends up in the upper n bytes of staging
                    stg_d  = {cfg_data, stg_q[31:8]};
                    tcnt_d = '0;
                    if (cnt_q == 3'd1) begin
                        state_d = S_HDR;
                        case (id_q)
                            ID_GAIN[2:0]:  sh_gain_d  = stg_d[31:16];
                            ID_BIAS[2:0]:  sh_bias_d  = stg_d;
                            ID_SHIFT[2:0]: sh_shift_d = stg_d[28:24];
                            ID_INVSC[2:0]: sh_invsc_d = stg_d[31:16];
                            default:       sh_zp_d    = stg_d[31:24];
                        endcase
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_HDR;
                end else if (FRAME_TIMEOUT != 0) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            S_CWAIT: begin
                if (mlp_state_in == IDLE_STATE) begin
                    act_gain_d  = sh_gain_q;
                    act_bias_d  = sh_bias_q;
                    act_shift_d = sh_shift_q;
                    act_invsc_d = sh_invsc_q;
                    act_zp_d    = sh_zp_q;
                    pending_d   = 1'b0;
                    state_d     = S_HDR;
                end
            end

            default: state_d = S_HDR;
        endcase

        // Held start: collect while pending, consumed the cycle it is issued
        if (pending_q) begin
            if (ctrl_start_mlp) begin
                held_d = 1'b1;
            end
        end else begin
            held_d = 1'b0;
        end
    end

    // State, shadow and active registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HDR;
            id_q        <= 3'd0;
            cnt_q       <= 3'd0;
            stg_q       <= 32'd0;
            tcnt_q      <= '0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            held_q      <= 1'b0;
            sh_gain_q   <= DEF_GAIN;
            sh_bias_q   <= DEF_BIAS;
            sh_shift_q  <= DEF_SHIFT;
            sh_invsc_q  <= DEF_INVSC;
            sh_zp_q     <= DEF_ZP;
            act_gain_q  <= DEF_GAIN;
            act_bias_q  <= DEF_BIAS;
            act_shift_q <= DEF_SHIFT;
            act_invsc_q <= DEF_INVSC;
            act_zp_q    <= DEF_ZP;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            stg_q       <= stg_d;
            tcnt_q      <= tcnt_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            held_q      <= held_d;
            sh_gain_q   <= sh_gain_d;
            sh_bias_q   <= sh_bias_d;
            sh_shift_q  <= sh_shift_d;
            sh_invsc_q  <= sh_invsc_d;
            sh_zp_q     <= sh_zp_d;
            act_gain_q  <= act_gain_d;
            act_bias_q  <= act_bias_d;
            act_shift_q <= act_shift_d;
            act_invsc_q <= act_invsc_d;
            act_zp_q    <= act_zp_d;
        end
    end

`ifdef MLP_CFG_READBACK_EN
    logic [31:0] rd_data_q, rd_data_d;

    // Readback mux: signed fields sign-extended, shift zero-extended
    always_comb begin
        rd_data_d = {31'd0, pending_q};
        case (rd_sel)
            3'd0:    rd_data_d = {{16{act_gain_q[15]}}, act_gain_q};
            3'd1:    rd_data_d = act_bias_q;
            3'd2:    rd_data_d = {27'd0, act_shift_q};
            3'd3:    rd_data_d = {{16{act_invsc_q[15]}}, act_invsc_q};
            3'd4:    rd_data_d = {{24{act_zp_q[7]}}, act_zp_q};
            default: rd_data_d = {31'd0, pending_q};
        endcase
    end

    // One-cycle registered readback
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 32'd0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule
